// File: rtl/add_rs_cdb_issue.sv
// Issue stage of the Tomasulo core: fetch latch, operand lookup, rename,
// dispatch to a 3-entry add reservation station or an external station,
// and the fixed-priority common-data-bus arbiter.
module add_rs_cdb_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_fetch_valid,
  input  logic [5:0]  in_operator_type,
  input  logic [4:0]  in_reg_1,
  input  logic [4:0]  in_reg_2,
  input  logic [4:0]  in_reg_3,
  input  logic [3:0]  in_ICC_flags,
  output logic        out_fetch_next,
  output logic        out_lookup_en,
  output logic [4:0]  out_reg_1,
  output logic [4:0]  out_reg_2,
  input  logic        in_status_valid,
  input  logic [31:0] in_val_1,
  input  logic [31:0] in_val_2,
  input  logic [4:0]  in_tag_1,
  input  logic [4:0]  in_tag_2,
  output logic        out_bank_enable,
  output logic [4:0]  out_bank_reg,
  output logic [4:0]  out_bank_tag,
  input  logic        in_ext_free,
  input  logic [4:0]  in_ext_tag,
  output logic        out_ext_dispatch,
  output logic [5:0]  out_operator_type,
  output logic [31:0] out_val_1,
  output logic [31:0] out_val_2,
  output logic [4:0]  out_tag_1,
  output logic [4:0]  out_tag_2,
  output logic [3:0]  out_ICC_flags,
  input  logic        in_request_mul,
  input  logic        in_request_logic,
  input  logic        in_request_load,
  input  logic        in_request_store,
  input  logic [4:0]  in_tag_mul,
  input  logic [4:0]  in_tag_logic,
  input  logic [4:0]  in_tag_load,
  input  logic [4:0]  in_tag_store,
  input  logic [31:0] in_val_mul,
  input  logic [31:0] in_val_logic,
  input  logic [31:0] in_val_load,
  input  logic [31:0] in_val_store,
  output logic        out_grant_mul,
  output logic        out_grant_logic,
  output logic        out_grant_load,
  output logic        out_grant_store,
  output logic        out_CDB_broadcast,
  output logic [4:0]  out_CDB_tag,
  output logic [31:0] out_CDB_val
);

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned N_ENT  = 3;
  localparam int unsigned IDX_W  = 2;

  localparam logic [TAG_W-1:0] INVALID_TAG  = 5'h1F;
  localparam logic [OP_W-1:0]  ADD_OP       = 6'b000000;
  localparam logic [OP_W-1:0]  ADDX_OP      = 6'b001000;
  localparam logic [TAG_W-1:0] ADD_TAG_BASE = 5'd0;

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_STATUS, DISPATCH} state_t;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic              carry;
  } rs_entry_t;

  state_t state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [TAG_W-1:0]  r1_q, r2_q, r3_q;
  logic [3:0]        icc_q;
  logic [DATA_W-1:0] v1_q, v2_q;
  logic [TAG_W-1:0]  t1_q, t2_q;

  logic              cdb_bcast_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_val_q;

  rs_entry_t ent_q [N_ENT];

  logic              latch_fetch, cap_status, disp_fire, is_add, slot_free;
  logic              add_free, add_req, grant_add;
  logic [IDX_W-1:0]  free_idx, req_idx;
  logic [DATA_W-1:0] add_res;
  logic              sel_valid;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_val;
  logic [DATA_W-1:0] hv1, hv2, cv1, cv2;
  logic [TAG_W-1:0]  ht1, ht2, ct1, ct2;

  function automatic logic fwd_hit(input logic [TAG_W-1:0] tag, input logic bc,
                                   input logic [TAG_W-1:0] ctag);
    return bc && (tag != INVALID_TAG) && (tag == ctag);
  endfunction

  // Operand forwarding from the current CDB broadcast (held and incoming operands)
  always_comb begin
    hv1 = v1_q;     ht1 = t1_q;
    hv2 = v2_q;     ht2 = t2_q;
    cv1 = in_val_1; ct1 = in_tag_1;
    cv2 = in_val_2; ct2 = in_tag_2;
    if (fwd_hit(t1_q, cdb_bcast_q, cdb_tag_q)) begin hv1 = cdb_val_q; ht1 = INVALID_TAG; end
    if (fwd_hit(t2_q, cdb_bcast_q, cdb_tag_q)) begin hv2 = cdb_val_q; ht2 = INVALID_TAG; end
    if (fwd_hit(in_tag_1, cdb_bcast_q, cdb_tag_q)) begin cv1 = cdb_val_q; ct1 = INVALID_TAG; end
    if (fwd_hit(in_tag_2, cdb_bcast_q, cdb_tag_q)) begin cv2 = cdb_val_q; ct2 = INVALID_TAG; end
  end

  // Lowest free entry for allocation; lowest ready entry for the CDB request
  always_comb begin
    add_free = 1'b0;
    free_idx = '0;
    add_req  = 1'b0;
    req_idx  = '0;
    add_res  = '0;
    for (int i = int'(N_ENT) - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        add_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent_q[i].busy && ent_q[i].qj == INVALID_TAG && ent_q[i].qk == INVALID_TAG) begin
        add_req = 1'b1;
        req_idx = IDX_W'(i);
        add_res = ent_q[i].vj + ent_q[i].vk
                + DATA_W'(ent_q[i].carry && (ent_q[i].op == ADDX_OP));
      end
    end
  end

  // Issue FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Issue FSM next state and dispatch decode
  always_comb begin
    state_d          = state_q;
    latch_fetch      = 1'b0;
    cap_status       = 1'b0;
    disp_fire        = 1'b0;
    out_fetch_next   = 1'b0;
    out_lookup_en    = 1'b0;
    out_ext_dispatch = 1'b0;
    out_bank_enable  = 1'b0;
    out_bank_tag     = INVALID_TAG;
    is_add           = (op_q == ADD_OP) || (op_q == ADDX_OP);
    slot_free        = is_add ? add_free : in_ext_free;
    case (state_q)
      IDLE: begin
        out_fetch_next = 1'b1;
        if (in_fetch_valid) begin
          latch_fetch = 1'b1;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        out_lookup_en = 1'b1;
        state_d       = WAIT_STATUS;
      end
      WAIT_STATUS: begin
        if (in_status_valid) begin
          cap_status = 1'b1;
          state_d    = DISPATCH;
        end
      end
      DISPATCH: begin
        if (slot_free) begin
          disp_fire        = 1'b1;
          out_ext_dispatch = !is_add;
          out_bank_enable  = (r3_q != '0);
          out_bank_tag     = is_add ? ADD_TAG_BASE + TAG_W'(free_idx) : in_ext_tag;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched instruction fields and operand status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      icc_q <= '0;
      v1_q  <= '0;
      v2_q  <= '0;
      t1_q  <= INVALID_TAG;
      t2_q  <= INVALID_TAG;
    end else begin
      if (latch_fetch) begin
        op_q  <= in_operator_type;
        r1_q  <= in_reg_1;
        r2_q  <= in_reg_2;
        r3_q  <= in_reg_3;
        icc_q <= in_ICC_flags;
      end
      if (cap_status) begin
        v1_q <= cv1; t1_q <= ct1;
        v2_q <= cv2; t2_q <= ct2;
      end else if (state_q == DISPATCH) begin
        v1_q <= hv1; t1_q <= ht1;
        v2_q <= hv2; t2_q <= ht2;
      end
    end
  end

  // Add station entries: allocate, wake on CDB, free on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_ENT); i++) begin
        ent_q[i] <= '{busy: 1'b0, op: '0, vj: '0, vk: '0,
                      qj: INVALID_TAG, qk: INVALID_TAG, carry: 1'b0};
      end
    end else begin
      for (int i = 0; i < int'(N_ENT); i++) begin
        if (grant_add && req_idx == IDX_W'(i)) begin
          ent_q[i].busy <= 1'b0;
        end else if (ent_q[i].busy) begin
          if (fwd_hit(ent_q[i].qj, cdb_bcast_q, cdb_tag_q)) begin
            ent_q[i].vj <= cdb_val_q;
            ent_q[i].qj <= INVALID_TAG;
          end
          if (fwd_hit(ent_q[i].qk, cdb_bcast_q, cdb_tag_q)) begin
            ent_q[i].vk <= cdb_val_q;
            ent_q[i].qk <= INVALID_TAG;
          end
        end else if (disp_fire && is_add && free_idx == IDX_W'(i)) begin
          ent_q[i] <= '{busy: 1'b1, op: op_q, vj: hv1, vk: hv2,
                        qj: ht1, qk: ht2, carry: icc_q[0]};
        end
      end
    end
  end

  // Fixed-priority CDB arbiter: add > mul > logic > load > store
  always_comb begin
    grant_add       = 1'b0;
    out_grant_mul   = 1'b0;
    out_grant_logic = 1'b0;
    out_grant_load  = 1'b0;
    out_grant_store = 1'b0;
    sel_valid       = 1'b0;
    sel_tag         = INVALID_TAG;
    sel_val         = '0;
    if (add_req) begin
      grant_add = 1'b1;
      sel_valid = 1'b1;
      sel_tag   = ADD_TAG_BASE + TAG_W'(req_idx);
      sel_val   = add_res;
    end else if (in_request_mul) begin
      out_grant_mul = 1'b1;
      sel_valid     = 1'b1;
      sel_tag       = in_tag_mul;
      sel_val       = in_val_mul;
    end else if (in_request_logic) begin
      out_grant_logic = 1'b1;
      sel_valid       = 1'b1;
      sel_tag         = in_tag_logic;
      sel_val         = in_val_logic;
    end else if (in_request_load) begin
      out_grant_load = 1'b1;
      sel_valid      = 1'b1;
      sel_tag        = in_tag_load;
      sel_val        = in_val_load;
    end else if (in_request_store) begin
      out_grant_store = 1'b1;
      sel_valid       = 1'b1;
      sel_tag         = in_tag_store;
      sel_val         = in_val_store;
    end
  end

  // Registered CDB broadcast, valid the cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_bcast_q <= 1'b0;
      cdb_tag_q   <= INVALID_TAG;
      cdb_val_q   <= '0;
    end else begin
      cdb_bcast_q <= sel_valid;
      cdb_tag_q   <= sel_tag;
      cdb_val_q   <= sel_val;
    end
  end

  assign out_reg_1         = r1_q;
  assign out_reg_2         = r2_q;
  assign out_bank_reg      = r3_q;
  assign out_operator_type = op_q;
  assign out_ICC_flags     = icc_q;
  assign out_val_1         = hv1;
  assign out_val_2         = hv2;
  assign out_tag_1         = ht1;
  assign out_tag_2         = ht2;
  assign out_CDB_broadcast = cdb_bcast_q;
  assign out_CDB_tag       = cdb_tag_q;
  assign out_CDB_val       = cdb_val_q;

endmodule

// File: tb/tb_add_rs_cdb_issue.sv
// Directed bench for add_rs_cdb_issue: vector table of single-instruction
// add cases plus hand-written multi-cycle sequences.
module tb_add_rs_cdb_issue;

  localparam logic [4:0] INV  = 5'h1F;
  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] ADDX = 6'b001000;
  localparam logic [5:0] UMUL = 6'b001010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_fetch_valid;
  logic [5:0]  in_operator_type;
  logic [4:0]  in_reg_1, in_reg_2, in_reg_3;
  logic [3:0]  in_ICC_flags;
  logic        out_fetch_next, out_lookup_en;
  logic [4:0]  out_reg_1, out_reg_2;
  logic        in_status_valid;
  logic [31:0] in_val_1, in_val_2;
  logic [4:0]  in_tag_1, in_tag_2;
  logic        out_bank_enable;
  logic [4:0]  out_bank_reg, out_bank_tag;
  logic        in_ext_free;
  logic [4:0]  in_ext_tag;
  logic        out_ext_dispatch;
  logic [5:0]  out_operator_type;
  logic [31:0] out_val_1, out_val_2;
  logic [4:0]  out_tag_1, out_tag_2;
  logic [3:0]  out_ICC_flags;
  logic        in_request_mul, in_request_logic, in_request_load, in_request_store;
  logic [4:0]  in_tag_mul, in_tag_logic, in_tag_load, in_tag_store;
  logic [31:0] in_val_mul, in_val_logic, in_val_load, in_val_store;
  logic        out_grant_mul, out_grant_logic, out_grant_load, out_grant_store;
  logic        out_CDB_broadcast;
  logic [4:0]  out_CDB_tag;
  logic [31:0] out_CDB_val;

  int n_cmp = 0;
  int n_bad = 0;

  add_rs_cdb_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_fetch_valid(in_fetch_valid), .in_operator_type(in_operator_type),
    .in_reg_1(in_reg_1), .in_reg_2(in_reg_2), .in_reg_3(in_reg_3),
    .in_ICC_flags(in_ICC_flags),
    .out_fetch_next(out_fetch_next), .out_lookup_en(out_lookup_en),
    .out_reg_1(out_reg_1), .out_reg_2(out_reg_2),
    .in_status_valid(in_status_valid), .in_val_1(in_val_1), .in_val_2(in_val_2),
    .in_tag_1(in_tag_1), .in_tag_2(in_tag_2),
    .out_bank_enable(out_bank_enable), .out_bank_reg(out_bank_reg),
    .out_bank_tag(out_bank_tag),
    .in_ext_free(in_ext_free), .in_ext_tag(in_ext_tag),
    .out_ext_dispatch(out_ext_dispatch), .out_operator_type(out_operator_type),
    .out_val_1(out_val_1), .out_val_2(out_val_2),
    .out_tag_1(out_tag_1), .out_tag_2(out_tag_2), .out_ICC_flags(out_ICC_flags),
    .in_request_mul(in_request_mul), .in_request_logic(in_request_logic),
    .in_request_load(in_request_load), .in_request_store(in_request_store),
    .in_tag_mul(in_tag_mul), .in_tag_logic(in_tag_logic),
    .in_tag_load(in_tag_load), .in_tag_store(in_tag_store),
    .in_val_mul(in_val_mul), .in_val_logic(in_val_logic),
    .in_val_load(in_val_load), .in_val_store(in_val_store),
    .out_grant_mul(out_grant_mul), .out_grant_logic(out_grant_logic),
    .out_grant_load(out_grant_load), .out_grant_store(out_grant_store),
    .out_CDB_broadcast(out_CDB_broadcast), .out_CDB_tag(out_CDB_tag),
    .out_CDB_val(out_CDB_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [4:0]  r1, r2, r3;
    logic [3:0]  icc;
    logic [31:0] v1, v2;
    logic        bank_en;
    logic [31:0] cdb_val;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Drives one instruction from IDLE up to its first DISPATCH cycle (returns at that negedge)
  task automatic issue(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] r3, input logic [3:0] icc,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [4:0] t1, input logic [4:0] t2);
    @(negedge clk);
    chk("fetch_next_idle", out_fetch_next, 1'b1);
    in_fetch_valid   = 1'b1;
    in_operator_type = op;
    in_reg_1 = r1; in_reg_2 = r2; in_reg_3 = r3;
    in_ICC_flags = icc;
    @(negedge clk);
    in_fetch_valid  = 1'b0;
    chk("lookup_en", out_lookup_en, 1'b1);
    chk("lookup_reg_1", out_reg_1, r1);
    chk("lookup_reg_2", out_reg_2, r2);
    in_status_valid = 1'b1;
    in_val_1 = v1; in_val_2 = v2;
    in_tag_1 = t1; in_tag_2 = t2;
    @(negedge clk);
    chk("lookup_one_cycle", out_lookup_en, 1'b0);
    chk("fetch_next_busy", out_fetch_next, 1'b0);
    @(negedge clk);
    in_status_valid = 1'b0;
  endtask

  // Bounded wait for the next CDB broadcast, then compare it
  task automatic wait_cdb(input string nm, input logic [4:0] tag, input logic [31:0] val);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_CDB_broadcast) break;
    end
    chk({nm, "_bcast"}, out_CDB_broadcast, 1'b1);
    chk({nm, "_tag"}, out_CDB_tag, tag);
    chk({nm, "_val"}, out_CDB_val, val);
  endtask

  task automatic chk_cdb(input string nm, input logic [4:0] tag, input logic [31:0] val);
    chk({nm, "_bcast"}, out_CDB_broadcast, 1'b1);
    chk({nm, "_tag"}, out_CDB_tag, tag);
    chk({nm, "_val"}, out_CDB_val, val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"plain_add",  ADD,  5'd0, 5'd1, 5'd2, 4'h0, 32'd5,        32'd7, 1'b1, 32'd12};
    vecs[1] = '{"addx_c1",    ADDX, 5'd1, 5'd2, 5'd3, 4'h1, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h00000000};
    vecs[2] = '{"addx_c0",    ADDX, 5'd1, 5'd2, 5'd3, 4'hE, 32'hFFFFFFFF, 32'd0, 1'b1, 32'hFFFFFFFF};
    vecs[3] = '{"add_wrap",   ADD,  5'd3, 5'd4, 5'd4, 4'h0, 32'hFFFFFFFF, 32'd2, 1'b1, 32'd1};
    vecs[4] = '{"add_no_c",   ADD,  5'd5, 5'd6, 5'd5, 4'hF, 32'd10,       32'd20, 1'b1, 32'd30};
    vecs[5] = '{"add_dest0",  ADD,  5'd7, 5'd8, 5'd0, 4'h0, 32'd100,      32'd200, 1'b0, 32'd300};

    rst_n = 1'b0;
    in_fetch_valid = 1'b0; in_operator_type = '0;
    in_reg_1 = '0; in_reg_2 = '0; in_reg_3 = '0; in_ICC_flags = '0;
    in_status_valid = 1'b0; in_val_1 = '0; in_val_2 = '0; in_tag_1 = INV; in_tag_2 = INV;
    in_ext_free = 1'b0; in_ext_tag = 5'd8;
    in_request_mul = 1'b0; in_request_logic = 1'b0;
    in_request_load = 1'b0; in_request_store = 1'b0;
    in_tag_mul = '0; in_tag_logic = '0; in_tag_load = '0; in_tag_store = '0;
    in_val_mul = '0; in_val_logic = '0; in_val_load = '0; in_val_store = '0;

    // Reset state
    #12;
    chk("rst_fetch_next", out_fetch_next, 1'b1);
    chk("rst_cdb_bcast", out_CDB_broadcast, 1'b0);
    chk("rst_cdb_tag", out_CDB_tag, INV);
    chk("rst_cdb_val", out_CDB_val, 32'd0);
    chk("rst_bank_en", out_bank_enable, 1'b0);
    chk("rst_ext_disp", out_ext_dispatch, 1'b0);
    chk("rst_tag_1", out_tag_1, INV);
    chk("rst_grant_mul", out_grant_mul, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single add instructions with ready operands
    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].op, vecs[v].r1, vecs[v].r2, vecs[v].r3, vecs[v].icc,
            vecs[v].v1, vecs[v].v2, INV, INV);
      chk({vecs[v].name, "_bank_en"}, out_bank_enable, vecs[v].bank_en);
      chk({vecs[v].name, "_ext_disp"}, out_ext_dispatch, 1'b0);
      if (vecs[v].bank_en) begin
        chk({vecs[v].name, "_bank_reg"}, out_bank_reg, vecs[v].r3);
        chk({vecs[v].name, "_bank_tag"}, out_bank_tag, 5'd0);
      end
      wait_cdb(vecs[v].name, 5'd0, vecs[v].cdb_val);
    end

    // Dependence wakeup: operand 1 waits on mul tag 5
    issue(ADD, 5'd4, 5'd5, 5'd6, 4'h0, 32'd0, 32'd3, 5'h05, INV);
    chk("dep_bank_tag", out_bank_tag, 5'd0);
    repeat (3) begin
      @(negedge clk);
      chk("dep_no_bcast", out_CDB_broadcast, 1'b0);
    end
    in_request_mul = 1'b1; in_tag_mul = 5'd5; in_val_mul = 32'd10;
    #1;
    chk("dep_grant_mul", out_grant_mul, 1'b1);
    @(negedge clk);
    in_request_mul = 1'b0;
    chk_cdb("dep_mul", 5'd5, 32'd10);
    #1;
    chk("dep_grant_mul_drop", out_grant_mul, 1'b0);
    @(negedge clk);
    chk("dep_grant_add", out_CDB_broadcast, 1'b0);
    @(negedge clk);
    chk_cdb("dep_add", 5'd0, 32'd13);

    // Arbitration: add and mul requesting in the same cycle
    issue(ADD, 5'd1, 5'd2, 5'd7, 4'h0, 32'd20, 32'd22, INV, INV);
    @(negedge clk);
    in_request_mul = 1'b1; in_tag_mul = 5'd9; in_val_mul = 32'd55;
    #1;
    chk("arb_mul_blocked", out_grant_mul, 1'b0);
    @(negedge clk);
    chk_cdb("arb_add_first", 5'd0, 32'd42);
    chk("arb_grant_mul", out_grant_mul, 1'b1);
    @(negedge clk);
    in_request_mul = 1'b0;
    chk_cdb("arb_mul_next", 5'd9, 32'd55);
    @(negedge clk);
    chk("arb_idle", out_CDB_broadcast, 1'b0);

    // Lower priority order: logic > load > store
    in_request_logic = 1'b1; in_tag_logic = 5'd11; in_val_logic = 32'd1;
    in_request_load  = 1'b1; in_tag_load  = 5'd12; in_val_load  = 32'd2;
    in_request_store = 1'b1; in_tag_store = 5'd13; in_val_store = 32'd3;
    #1;
    chk("pri_logic", out_grant_logic, 1'b1);
    chk("pri_load_wait", out_grant_load, 1'b0);
    @(negedge clk);
    in_request_logic = 1'b0;
    chk_cdb("pri_logic_cdb", 5'd11, 32'd1);
    #1;
    chk("pri_load", out_grant_load, 1'b1);
    chk("pri_store_wait", out_grant_store, 1'b0);
    @(negedge clk);
    in_request_load = 1'b0;
    chk_cdb("pri_load_cdb", 5'd12, 32'd2);
    #1;
    chk("pri_store", out_grant_store, 1'b1);
    @(negedge clk);
    in_request_store = 1'b0;
    chk_cdb("pri_store_cdb", 5'd13, 32'd3);

    // Full station: three adds wait on tag 0x1E, the fourth stalls
    issue(ADD, 5'd1, 5'd2, 5'd10, 4'h0, 32'd0, 32'd1, 5'h1E, INV);
    chk("full_tag0", out_bank_tag, 5'd0);
    issue(ADD, 5'd1, 5'd2, 5'd11, 4'h0, 32'd0, 32'd2, 5'h1E, INV);
    chk("full_tag1", out_bank_tag, 5'd1);
    issue(ADD, 5'd1, 5'd2, 5'd12, 4'h0, 32'd0, 32'd3, 5'h1E, INV);
    chk("full_tag2", out_bank_tag, 5'd2);
    issue(ADD, 5'd1, 5'd2, 5'd13, 4'h0, 32'd0, 32'd10, 5'h1E, INV);
    chk("full_stall_bank", out_bank_enable, 1'b0);
    chk("full_stall_fetch", out_fetch_next, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("full_still_stalled", out_fetch_next, 1'b0);
    end
    in_request_load = 1'b1; in_tag_load = 5'h1E; in_val_load = 32'd4;
    #1;
    chk("full_grant_load", out_grant_load, 1'b1);
    @(negedge clk);
    in_request_load = 1'b0;
    chk_cdb("full_load_cdb", 5'h1E, 32'd4);
    chk("full_stall_s1", out_bank_enable, 1'b0);
    @(negedge clk);
    chk("full_stall_s2", out_bank_enable, 1'b0);
    @(negedge clk);
    chk("full_disp_bank", out_bank_enable, 1'b1);
    chk("full_disp_tag", out_bank_tag, 5'd0);
    chk("full_disp_reg", out_bank_reg, 5'd13);
    chk("full_fwd_tag", out_tag_1, INV);
    chk("full_fwd_val", out_val_1, 32'd4);
    chk_cdb("full_e0", 5'd0, 32'd5);
    @(negedge clk);
    chk("full_idle", out_fetch_next, 1'b1);
    chk_cdb("full_e1", 5'd1, 32'd6);
    @(negedge clk);
    chk_cdb("full_e0_new", 5'd0, 32'd14);
    @(negedge clk);
    chk_cdb("full_e2", 5'd2, 32'd7);
    @(negedge clk);
    chk("full_drained", out_CDB_broadcast, 1'b0);

    // External dispatch with a stall while the external station is full
    in_ext_free = 1'b0; in_ext_tag = 5'd8;
    issue(UMUL, 5'd3, 5'd4, 5'd9, 4'h0, 32'd6, 32'd7, INV, INV);
    chk("ext_stall_disp", out_ext_dispatch, 1'b0);
    chk("ext_stall_bank", out_bank_enable, 1'b0);
    @(negedge clk);
    chk("ext_stall_fetch", out_fetch_next, 1'b0);
    in_ext_free = 1'b1;
    #1;
    chk("ext_disp", out_ext_dispatch, 1'b1);
    chk("ext_bank_en", out_bank_enable, 1'b1);
    chk("ext_bank_tag", out_bank_tag, 5'd8);
    chk("ext_bank_reg", out_bank_reg, 5'd9);
    chk("ext_op", out_operator_type, UMUL);
    chk("ext_val_1", out_val_1, 32'd6);
    chk("ext_val_2", out_val_2, 32'd7);
    @(negedge clk);
    in_ext_free = 1'b0;
    chk("ext_disp_pulse", out_ext_dispatch, 1'b0);
    chk("ext_back_idle", out_fetch_next, 1'b1);
    chk("ext_no_add_bcast", out_CDB_broadcast, 1'b0);

    // Reset mid-operation: busy entry, instruction in flight, pending grant
    issue(ADD, 5'd1, 5'd2, 5'd14, 4'h0, 32'd0, 32'd1, 5'h1E, INV);
    @(negedge clk);
    in_fetch_valid = 1'b1; in_operator_type = ADD; in_reg_3 = 5'd15;
    @(negedge clk);
    in_fetch_valid = 1'b0;
    in_request_store = 1'b1; in_tag_store = 5'd3; in_val_store = 32'd99;
    #1;
    chk("mid_grant_store", out_grant_store, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    in_request_store = 1'b0;
    chk("mid_rst_fetch", out_fetch_next, 1'b1);
    chk("mid_rst_lookup", out_lookup_en, 1'b0);
    chk("mid_rst_bcast", out_CDB_broadcast, 1'b0);
    chk("mid_rst_cdb_tag", out_CDB_tag, INV);
    chk("mid_rst_bank_tag", out_bank_tag, INV);
    @(negedge clk);
    chk("mid_rst_no_bcast", out_CDB_broadcast, 1'b0);
    rst_n = 1'b1;
    issue(ADD, 5'd1, 5'd2, 5'd16, 4'h0, 32'd8, 32'd9, INV, INV);
    chk("post_rst_tag", out_bank_tag, 5'd0);
    wait_cdb("post_rst", 5'd0, 32'd17);
    @(negedge clk);
    chk("post_rst_quiet", out_CDB_broadcast, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_rs_cdb_issue.md
# add_rs_cdb_issue

Issue-and-add slice of the Tomasulo core: latches one fetched instruction, looks up operand status, renames the destination, and dispatches it. ADD/ADDX go to an internal 3-entry add reservation station; other ops go to an external station. The block also holds the common-data-bus (CDB) arbiter that serialises results from the add station and from the external mul, logic, load and store units.

## Interface
- `INVALID_TAG`, 5'h1F: tag value meaning "operand value present".
- `ADD_OP`, 6'b000000: opcode for ADD.
- `ADDX_OP`, 6'b001000: opcode for ADDX (add with carry).
- `ADD_TAG_BASE`, 5'd0: tag of add-station entry 0; entries use BASE..BASE+2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_fetch_valid`  in  1  new instruction present.
- `in_operator_type` [5:0], `in_reg_1` [4:0], `in_reg_2` [4:0], `in_reg_3` [4:0] (dest), `in_ICC_flags` [3:0] (NZVC; C = bit 0)  in  instruction fields.
- `out_fetch_next`  out  1  ready to accept an instruction.
- `out_lookup_en`, `out_reg_1`, `out_reg_2`  out  1/5/5  register-status lookup.
- `in_status_valid`, `in_val_1`, `in_val_2` [31:0], `in_tag_1`, `in_tag_2` [4:0]  in  lookup reply.
- `out_bank_enable`, `out_bank_reg` [4:0], `out_bank_tag` [4:0]  out  destination rename write.
- `in_ext_free`, `in_ext_tag` [4:0]  in  external station has a free slot / its tag.
- `out_ext_dispatch`  out  1  dispatch pulse to the external station.
- `out_operator_type`, `out_val_1`, `out_val_2`, `out_tag_1`, `out_tag_2`, `out_ICC_flags`  out  dispatched operands.
- `in_request_{mul,logic,load,store}`, `in_tag_*` [4:0], `in_val_*` [31:0]  in  external CDB requests.
- `out_grant_{mul,logic,load,store}`  out  1  one-cycle grant pulse.
- `out_CDB_broadcast`, `out_CDB_tag` [4:0], `out_CDB_val` [31:0]  out  CDB.

## Operation
- **Issue FSM states:** IDLE → LOOKUP → WAIT_STATUS → DISPATCH → IDLE.
- **IDLE:**
  - `out_fetch_next` = 1.
  - `in_fetch_valid` high at an edge latches all instruction fields and moves to LOOKUP.
- **LOOKUP:** drives `out_lookup_en` = 1 with `out_reg_1`/`out_reg_2` for exactly one cycle.
- **WAIT_STATUS:** first cycle with `in_status_valid` = 1 captures the values and tags.
- **CDB forwarding:** a captured or held tag that equals `out_CDB_tag` while `out_CDB_broadcast` = 1 is replaced by `out_CDB_val`, with the tag set to INVALID_TAG. This applies in WAIT_STATUS and DISPATCH.
- **DISPATCH target:** ADD/ADDX go to the add station; all other opcodes go to the external station.
- **DISPATCH stall:** the FSM stalls while the target has no free slot (add: no free entry; external: `in_ext_free` = 0).
- **DISPATCH cycle:**
  - Writes the add entry or pulses `out_ext_dispatch`.
  - Pulses `out_bank_enable` with `out_bank_reg` = dest and `out_bank_tag` = allocated tag.
  - When dest = 0, bank write is suppressed.
  - Add tag allocation uses the lowest-index free entry.
- **Add station entry fields:** busy, op, Vj, Vk, Qj, Qk, carry.
  - An entry waiting on Qj/Qk captures the CDB value on a tag match.
  - An entry is ready when busy and Qj = Qk = INVALID_TAG.
- **Add result:** Vj + Vk, plus ICC C for ADDX; 32-bit, wraps modulo 2^32, no flag output.
- **Add CDB request:** the lowest-index ready entry raises the internal add request with its tag and result.
  - It holds the request until granted.
  - The entry frees at the grant edge.
- **CDB arbiter:** fixed priority add > mul > logic > load > store; one grant per cycle.
  - External requesters hold their request until their grant pulse.
- **Reset values:**
  - FSM in IDLE; `out_fetch_next` = 1.
  - All enables, dispatch pulses, grants and `out_CDB_broadcast` = 0.
  - All tag outputs = INVALID_TAG; values = 0; add entries not busy.

## Timing
- **Issue latency:** fetch edge t → lookup in cycle t+1 → status captured at the first edge with `in_status_valid`.
- **Dispatch:** dispatch and bank write occur in the cycle after status capture if a slot is free; IDLE follows on the next edge.
- **Fetch acceptance:** `out_fetch_next` is low from the fetch edge until the FSM returns to IDLE.
- **Grant to broadcast:** grant is decided combinationally in cycle g; `out_CDB_*` is registered and valid in cycle g+1 for one cycle.
- **Wakeup to request:** an entry dispatched ready, or woken by a broadcast in cycle b, may request in cycle b+1.
- **Same-cycle free and allocate:** an entry freed by grant at edge e is allocatable by a DISPATCH after e.
- **Simultaneous dispatch and broadcast:** forwarding applies, so a dispatched operand never misses that broadcast.
- **Reset mid-operation:** asynchronous reset discards the latched instruction and all entries, and cancels any pending grant.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run → `out_fetch_next` = 1, `out_CDB_broadcast` = 0, `out_CDB_tag` = 5'h1F, no busy entries.
- **Plain ADD:** ADD r0+r1→r2 with values 5 and 7, tags INVALID → bank write reg 2 tag 0; CDB broadcast tag 0, value 12.
- **ADDX wrap:** ADDX with 0xFFFFFFFF + 0 and C = 1 → CDB value 0x00000000; same operands with C = 0 → 0xFFFFFFFF.
- **Dependence wakeup:** ADD with `in_tag_1` = 5'h05 pending; external mul broadcasts tag 5, value 10, `in_val_2` = 3 → add station broadcasts 13 one cycle after wakeup plus arbitration.
- **Arbitration:** add and mul request in the same cycle → add broadcast first; `out_grant_mul` pulses and mul broadcasts next cycle.
- **Full station and external dispatch:**
  - Four ADDs on a never-broadcast tag → fourth stalls in DISPATCH with `out_fetch_next` = 0 until a slot frees.
  - UMUL (6'b001010) with `in_ext_free` = 1, `in_ext_tag` = 8 → `out_ext_dispatch` pulses; bank tag 8.
